// File: rtl/regfile_pkg.sv
// Shared defaults and sizing helpers for the scoreboarded register file.
package regfile_pkg;

  localparam int RF_NUM_REGS     = 32;
  localparam int RF_DATA_WIDTH   = 32;
  localparam int RF_NUM_RD_PORTS = 2;
  localparam int RF_MAX_PENDING  = 4;

  // Counter must be able to hold the value MAX_PENDING itself.
  function automatic int pend_cnt_width(input int max_pending);
    return $clog2(max_pending + 1);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Tracks outstanding long-latency writes: per-register pending bits,
// an outstanding-op counter, issue gating and a sticky protocol error.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS     = RF_NUM_REGS,
  parameter int NUM_RD_PORTS = RF_NUM_RD_PORTS,
  parameter int MAX_PENDING  = RF_MAX_PENDING,
  localparam int AW = $clog2(NUM_REGS),
  localparam int CW = pend_cnt_width(MAX_PENDING)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD_PORTS*AW-1:0] rs_addr_i,
  output logic [NUM_RD_PORTS-1:0]    rs_busy_o,
  input  logic                       wb1_we_i,
  input  logic [AW-1:0]              wb1_addr_i,
  input  logic                       issue_i,
  input  logic [AW-1:0]              issue_rd_i,
  output logic                       issue_ready_o,
  output logic [CW-1:0]              pending_cnt_o,
  output logic                       err_o
);

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PENDING);

  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                accept;

  // Issue gating looks only at registered state; a completion in the same
  // cycle does not free a slot or a destination until the next edge.
  always_comb begin
    issue_ready_o = (cnt_q != CNT_MAX) && !pend_q[issue_rd_i];
    accept        = issue_i && issue_ready_o;
  end

  // Next-state for pending bits, counter and error flag.
  always_comb begin
    pend_d = pend_q;
    if (wb1_we_i) pend_d[wb1_addr_i] = 1'b0;
    if (accept && (issue_rd_i != '0)) pend_d[issue_rd_i] = 1'b1;
    pend_d[0] = 1'b0;

    cnt_d = cnt_q;
    if (accept && !wb1_we_i) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end else if (!accept && wb1_we_i) begin
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end

    // A completion is unexpected if nothing is outstanding, or if it lands
    // on a nonzero register nobody issued to (x0 issues set no bit).
    err_d = err_q;
    if (wb1_we_i && ((cnt_q == '0) ||
                     ((wb1_addr_i != '0) && !pend_q[wb1_addr_i])))
      err_d = 1'b1;
  end

  // Scoreboard state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  // Source busy: pending and not being completed this very cycle.
  always_comb begin
    rs_busy_o = '0;
    for (int k = 0; k < NUM_RD_PORTS; k++) begin
      rs_busy_o[k] = pend_q[rs_addr_i[k*AW +: AW]] &&
                     !(wb1_we_i && (wb1_addr_i == rs_addr_i[k*AW +: AW]));
    end
  end

  assign pending_cnt_o = cnt_q;
  assign err_o         = err_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-through bypass and a scoreboard for
// long-latency (MUL/DIV) destinations. x0 is hardwired to zero.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int NUM_REGS     = RF_NUM_REGS,
  parameter int DATA_WIDTH   = RF_DATA_WIDTH,
  parameter int NUM_RD_PORTS = RF_NUM_RD_PORTS,
  parameter int MAX_PENDING  = RF_MAX_PENDING,
  localparam int AW = $clog2(NUM_REGS),
  localparam int CW = pend_cnt_width(MAX_PENDING)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_RD_PORTS*AW-1:0]         rs_addr_i,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rs_data_o,
  output logic [NUM_RD_PORTS-1:0]            rs_busy_o,
  input  logic                               wb0_we_i,
  input  logic [AW-1:0]                      wb0_addr_i,
  input  logic [DATA_WIDTH-1:0]              wb0_data_i,
  input  logic                               wb1_we_i,
  input  logic [AW-1:0]                      wb1_addr_i,
  input  logic [DATA_WIDTH-1:0]              wb1_data_i,
  input  logic                               issue_i,
  input  logic [AW-1:0]                      issue_rd_i,
  output logic                               issue_ready_o,
  output logic [CW-1:0]                      pending_cnt_o,
  output logic                               err_o
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  // Storage update; wb0 is written last so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      if (wb1_we_i && (wb1_addr_i != '0) && (int'(wb1_addr_i) < NUM_REGS))
        regs_q[wb1_addr_i] <= wb1_data_i;
      if (wb0_we_i && (wb0_addr_i != '0) && (int'(wb0_addr_i) < NUM_REGS))
        regs_q[wb0_addr_i] <= wb0_data_i;
    end
  end

  // Combinational read with same-cycle bypass, wb0 ahead of wb1.
  always_comb begin
    logic [AW-1:0] a;
    rs_data_o = '0;
    for (int k = 0; k < NUM_RD_PORTS; k++) begin
      a = rs_addr_i[k*AW +: AW];
      if (a == '0)
        rs_data_o[k*DATA_WIDTH +: DATA_WIDTH] = '0;
      else if (wb0_we_i && (wb0_addr_i == a))
        rs_data_o[k*DATA_WIDTH +: DATA_WIDTH] = wb0_data_i;
      else if (wb1_we_i && (wb1_addr_i == a))
        rs_data_o[k*DATA_WIDTH +: DATA_WIDTH] = wb1_data_i;
      else if (int'(a) < NUM_REGS)
        rs_data_o[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[a];
    end
  end

  rf_scoreboard #(
    .NUM_REGS     (NUM_REGS),
    .NUM_RD_PORTS (NUM_RD_PORTS),
    .MAX_PENDING  (MAX_PENDING)
  ) u_sb (
    .clk           (clk),
    .rst           (rst),
    .rs_addr_i     (rs_addr_i),
    .rs_busy_o     (rs_busy_o),
    .wb1_we_i      (wb1_we_i),
    .wb1_addr_i    (wb1_addr_i),
    .issue_i       (issue_i),
    .issue_rd_i    (issue_rd_i),
    .issue_ready_o (issue_ready_o),
    .pending_cnt_o (pending_cnt_o),
    .err_o         (err_o)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed and random checks of regfile_sb against a behavioural model.
module tb_regfile_sb;

  localparam int NR = 32;
  localparam int DW = 32;
  localparam int NP = 2;
  localparam int MP = 4;
  localparam int AW = 5;
  localparam int CW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP*AW-1:0]  rs_addr_i;
  logic [NP*DW-1:0]  rs_data_o;
  logic [NP-1:0]     rs_busy_o;
  logic              wb0_we_i, wb1_we_i, issue_i;
  logic [AW-1:0]     wb0_addr_i, wb1_addr_i, issue_rd_i;
  logic [DW-1:0]     wb0_data_i, wb1_data_i;
  logic              issue_ready_o, err_o;
  logic [CW-1:0]     pending_cnt_o;

  regfile_sb dut (
    .clk(clk), .rst(rst),
    .rs_addr_i(rs_addr_i), .rs_data_o(rs_data_o), .rs_busy_o(rs_busy_o),
    .wb0_we_i(wb0_we_i), .wb0_addr_i(wb0_addr_i), .wb0_data_i(wb0_data_i),
    .wb1_we_i(wb1_we_i), .wb1_addr_i(wb1_addr_i), .wb1_data_i(wb1_data_i),
    .issue_i(issue_i), .issue_rd_i(issue_rd_i),
    .issue_ready_o(issue_ready_o), .pending_cnt_o(pending_cnt_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural values, set of destinations in flight,
  // number of outstanding ops, sticky error.
  logic [DW-1:0] m_regs [NR];
  bit            m_pend [NR];
  int            m_cnt;
  bit            m_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_read(input int a);
    if (a == 0) return '0;
    if (wb0_we_i && int'(wb0_addr_i) == a) return wb0_data_i;
    if (wb1_we_i && int'(wb1_addr_i) == a) return wb1_data_i;
    return m_regs[a];
  endfunction

  function automatic bit exp_busy(input int a);
    return m_pend[a] && !(wb1_we_i && int'(wb1_addr_i) == a);
  endfunction

  function automatic bit exp_ready();
    return (m_cnt < MP) && !m_pend[issue_rd_i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  // Apply one rising edge to the model using the inputs held across it.
  task automatic model_edge();
    bit acc;
    int delta;
    if (!rst) begin
      model_reset();
      return;
    end
    acc = issue_i && exp_ready();
    if (wb1_we_i && (m_cnt == 0 || (wb1_addr_i != 0 && !m_pend[wb1_addr_i])))
      m_err = 1'b1;
    if (wb1_we_i && wb1_addr_i != 0) m_regs[wb1_addr_i] = wb1_data_i;
    if (wb0_we_i && wb0_addr_i != 0) m_regs[wb0_addr_i] = wb0_data_i;
    if (wb1_we_i) m_pend[wb1_addr_i] = 1'b0;
    if (acc && issue_rd_i != 0) m_pend[issue_rd_i] = 1'b1;
    delta = int'(acc) - int'(wb1_we_i);
    m_cnt = m_cnt + delta;
    if (m_cnt < 0) m_cnt = 0;
    if (m_cnt > MP) m_cnt = MP;
  endtask

  task automatic settle();
    #2;
    for (int k = 0; k < NP; k++) begin
      chk($sformatf("rd_data%0d", k), rs_data_o[k*DW +: DW], exp_read(rs_addr_i[k*AW +: AW]));
      chk($sformatf("rd_busy%0d", k), rs_busy_o[k], exp_busy(rs_addr_i[k*AW +: AW]));
    end
    chk("issue_ready", issue_ready_o, exp_ready());
    chk("pending_cnt", pending_cnt_o, m_cnt);
    chk("err", err_o, m_err);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rst = 1'b1;
    rs_addr_i = '0;
    wb0_we_i = 1'b0; wb0_addr_i = '0; wb0_data_i = '0;
    wb1_we_i = 1'b0; wb1_addr_i = '0; wb1_data_i = '0;
    issue_i = 1'b0;  issue_rd_i = '0;
  endtask

  task automatic set_rd(input int p, input int a);
    rs_addr_i[p*AW +: AW] = AW'(a);
  endtask

  initial begin
    int q[$];
    model_reset();
    idle();
    @(posedge clk); #1;

    // Reset with junk traffic: nothing may land.
    rst = 1'b0; wb0_we_i = 1'b1; wb0_addr_i = 5'd6; wb0_data_i = 32'hFFFF_0000;
    issue_i = 1'b1; issue_rd_i = 5'd2;
    tick(); tick();
    idle(); set_rd(0, 6); set_rd(1, 2);
    settle();
    chk("rst_data6", rs_data_o[DW-1:0], 32'h0);
    chk("rst_busy", rs_busy_o, 2'b00);
    chk("rst_ready", issue_ready_o, 1'b1);
    chk("rst_cnt", pending_cnt_o, 0);
    chk("rst_err", err_o, 1'b0);
    tick();

    // x5 write then read; x0 write discarded.
    idle(); wb0_we_i = 1'b1; wb0_addr_i = 5'd5; wb0_data_i = 32'hDEADBEEF; settle(); tick();
    idle(); set_rd(0, 5); settle();
    chk("x5_read", rs_data_o[DW-1:0], 32'hDEADBEEF);
    tick();
    idle(); wb0_we_i = 1'b1; wb0_addr_i = 5'd0; wb0_data_i = 32'h1; settle(); tick();
    idle(); set_rd(0, 0); settle();
    chk("x0_read", rs_data_o[DW-1:0], 32'h0);
    tick();

    // Same-cycle bypass of wb0 on port 1.
    idle(); wb0_we_i = 1'b1; wb0_addr_i = 5'd7; wb0_data_i = 32'h12345678; set_rd(1, 7);
    settle();
    chk("bypass_p1", rs_data_o[DW +: DW], 32'h12345678);
    tick();

    // Scoreboard on x3 with WAW block and completion bypass.
    idle(); issue_i = 1'b1; issue_rd_i = 5'd3; settle(); tick();
    idle(); set_rd(0, 3); settle();
    chk("x3_busy", rs_busy_o[0], 1'b1);
    issue_i = 1'b1; issue_rd_i = 5'd3; settle();
    chk("waw_block", issue_ready_o, 1'b0);
    tick();
    idle(); set_rd(0, 3); wb1_we_i = 1'b1; wb1_addr_i = 5'd3; wb1_data_i = 32'hAA; settle();
    chk("x3_release_busy", rs_busy_o[0], 1'b0);
    chk("x3_release_data", rs_data_o[DW-1:0], 32'hAA);
    tick();
    idle(); settle();
    chk("x3_cnt_zero", pending_cnt_o, 0);
    tick();

    // Fill to MAX_PENDING, then a completion does not reopen issue that cycle.
    for (int r = 1; r <= 4; r++) begin
      idle(); issue_i = 1'b1; issue_rd_i = AW'(r); settle(); tick();
    end
    idle(); settle();
    chk("full_cnt", pending_cnt_o, 4);
    chk("full_ready", issue_ready_o, 1'b0);
    wb1_we_i = 1'b1; wb1_addr_i = 5'd1; wb1_data_i = 32'h11; issue_i = 1'b1; issue_rd_i = 5'd5;
    settle();
    chk("full_no_same_cycle", issue_ready_o, 1'b0);
    tick();
    idle(); settle();
    chk("full_release_cnt", pending_cnt_o, 3);
    chk("full_release_err", err_o, 1'b0);
    tick();

    // Reset clears everything outstanding.
    idle(); rst = 1'b0; tick();

    // wb0/wb1 collision on x9.
    idle(); wb0_we_i = 1'b1; wb0_addr_i = 5'd9; wb0_data_i = 32'h1;
    wb1_we_i = 1'b1; wb1_addr_i = 5'd9; wb1_data_i = 32'h2; settle(); tick();
    idle(); set_rd(1, 9); settle();
    chk("x9_wb0_wins", rs_data_o[DW +: DW], 32'h1);
    tick();

    // Unexpected completion sets a sticky error cleared only by reset.
    idle(); rst = 1'b0; tick();
    idle(); wb1_we_i = 1'b1; wb1_addr_i = 5'd4; wb1_data_i = 32'h4; settle(); tick();
    idle(); settle();
    chk("err_set", err_o, 1'b1);
    tick(); tick(); tick();
    settle();
    chk("err_hold", err_o, 1'b1);
    rst = 1'b0; tick();
    idle(); settle();
    chk("err_cleared", err_o, 1'b0);
    tick();

    // Random traffic, mostly well-formed completions.
    for (int n = 0; n < 3000; n++) begin
      idle();
      rst = ($urandom_range(0, 149) != 0);
      set_rd(0, $urandom_range(0, NR - 1));
      set_rd(1, $urandom_range(0, NR - 1));
      wb0_we_i   = $urandom_range(0, 1);
      wb0_addr_i = AW'($urandom_range(0, NR - 1));
      wb0_data_i = $urandom;
      issue_i    = ($urandom_range(0, 2) != 0);
      issue_rd_i = AW'($urandom_range(0, 7));
      q.delete();
      for (int i = 1; i < NR; i++) if (m_pend[i]) q.push_back(i);
      wb1_we_i   = ($urandom_range(0, 2) == 0);
      wb1_data_i = $urandom;
      if (q.size() > 0 && $urandom_range(0, 9) != 0)
        wb1_addr_i = AW'(q[$urandom_range(0, q.size() - 1)]);
      else
        wb1_addr_i = AW'($urandom_range(0, NR - 1));
      if ($urandom_range(0, 3) == 0) begin
        set_rd(0, wb0_addr_i);
        set_rd(1, wb1_addr_i);
      end
      settle();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
